id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard control for the 5-stage LEGv8 pipeline. Captures decoded operands, register numbers and control from IF/ID. Inserts bubbles on load-use hazards and branch flushes. Drives the IDEX_rm/IDEX_rn/IDEX_rd fields consumed directly downstream by the forwarding unit and EX stage.

Parameters:
DATA_W, 64, operand/immediate width
CTRL_W, 8, width of the opaque EX/MEM/WB control bundle (passed through)
STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
IFID_Valid  input  1  IF/ID holds a real instruction
IFID_rm  input  5  source register A
IFID_rn  input  5  source register B
IFID_rd  input  5  destination register
IFID_RegWrite  input  1  instruction writes rd
IFID_MemRead  input  1  instruction is a load
IFID_Ctrl  input  CTRL_W  remaining control bits
IFID_ReadData1  input  DATA_W  register file port 1 data
IFID_ReadData2  input  DATA_W  register file port 2 data
IFID_Imm  input  DATA_W  sign-extended immediate
Branching  input  1  branch taken, flush the younger instruction
Stall  output  1  combinational; hold PC and IF/ID this cycle
IDEX_Valid, IDEX_rm, IDEX_rn, IDEX_rd, IDEX_RegWrite, IDEX_MemRead, IDEX_Ctrl, IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm  output  matching widths  registered copies

Behaviour:
- Reset (async, active-high): all IDEX_* outputs = 0, state = RUN, counter = 0, Stall = 0. Reset asserted mid-stall aborts the stall immediately.
- Bubble: IDEX_Valid, IDEX_RegWrite, IDEX_MemRead, IDEX_Ctrl, IDEX_rm, IDEX_rn, IDEX_rd and all data fields are loaded as 0.
- Hazard (combinational): IFID_Valid & IDEX_Valid & IDEX_MemRead & IDEX_rd != 31 & (IDEX_rd == IFID_rm | IDEX_rd == IFID_rn). X31 (XZR) never creates a hazard.
- States: RUN and STALL, with a 3-bit counter.
- Stall = ~Branching & (state == STALL | (state == RUN & Hazard)).
- Per posedge, in priority order:
  1. Branching = 1: load bubble; state -> RUN; counter -> 0.
  2. RUN & Hazard: load bubble. If STALL_CYCLES == 1, stay in RUN. Otherwise state -> STALL and counter = STALL_CYCLES - 1.
  3. STALL: load bubble; counter decrements; when counter reaches 1 and decrements, state -> RUN.
  4. RUN, no hazard: load IFID_* fields. IFID_Valid = 0 loads a bubble.
- The bubble clears IDEX_MemRead, so a hazard is never re-detected against itself. The stalled instruction enters ID/EX exactly STALL_CYCLES cycles after detection.
- Latency: one cycle from IF/ID to ID/EX. Data is captured unmodified; no arithmetic is performed.
- Hazard and Branching in the same cycle: Branching wins and no stall occurs.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- When defined, adds two ports:
  - StallCount (output, 32): increments on each posedge where Stall = 1.
  - FlushCount (output, 32): increments on each posedge where Branching = 1 & IDEX_Valid-to-be (IFID_Valid or stall in progress).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist; core behaviour is identical.

Test Plan:
1. Reset asserted asynchronously between edges while in STALL with STALL_CYCLES = 3 -> all outputs 0 immediately, Stall = 0, and the next valid IFID instruction is captured on the following edge.
2. LDUR X1 followed by ADD with rm = 1 (STALL_CYCLES = 1) -> Stall = 1 for exactly one cycle, one bubble (IDEX_Valid = 0), then IDEX_rm = 1 with IDEX_Valid = 1.
3. LDUR X31 followed by ADD with rn = 31 -> Stall stays 0 and there are no bubbles.
4. Load-use with STALL_CYCLES = 3 -> Stall high for 3 consecutive cycles, 3 bubbles, then the dependent instruction is captured.
5. Branching = 1 in the second stall cycle (STALL_CYCLES = 3) -> Stall drops in that cycle, a bubble is loaded, state is RUN, and the next cycle captures the new IFID instruction.
6. With ID_EX_HAZARD_STATS_EN: two load-use hazards (STALL_CYCLES = 2) plus one flush -> StallCount = 4, FlushCount = 1. Preloading StallCount to saturation -> it holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and branch-flush bubbles.
// Define ID_EX_HAZARD_STATS_EN to add saturating StallCount/FlushCount outputs.
module id_ex_stage #(
  parameter int DATA_W       = 64,
  parameter int CTRL_W       = 8,
  parameter int STALL_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IFID_Valid,
  input  logic [4:0]        IFID_rm,
  input  logic [4:0]        IFID_rn,
  input  logic [4:0]        IFID_rd,
  input  logic              IFID_RegWrite,
  input  logic              IFID_MemRead,
  input  logic [CTRL_W-1:0] IFID_Ctrl,
  input  logic [DATA_W-1:0] IFID_ReadData1,
  input  logic [DATA_W-1:0] IFID_ReadData2,
  input  logic [DATA_W-1:0] IFID_Imm,
  input  logic              Branching,
`ifdef ID_EX_HAZARD_STATS_EN
  output logic [31:0]       StallCount,
  output logic [31:0]       FlushCount,
`endif
  output logic              Stall,
  output logic              IDEX_Valid,
  output logic [4:0]        IDEX_rm,
  output logic [4:0]        IDEX_rn,
  output logic [4:0]        IDEX_rd,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic [CTRL_W-1:0] IDEX_Ctrl,
  output logic [DATA_W-1:0] IDEX_ReadData1,
  output logic [DATA_W-1:0] IDEX_ReadData2,
  output logic [DATA_W-1:0] IDEX_Imm
);
  typedef enum logic {RUN, STALL} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic       hazard, load;
  // XZR is never a real producer, so it cannot create a load-use dependency
  assign hazard = IFID_Valid & IDEX_Valid & IDEX_MemRead & (IDEX_rd != 5'd31) &
                  ((IDEX_rd == IFID_rm) | (IDEX_rd == IFID_rn));
  assign Stall  = ~Branching & ((state == STALL) | ((state == RUN) & hazard));
  assign load   = ~Branching & (state == RUN) & ~hazard & IFID_Valid;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= RUN;
      cnt            <= '0;
      IDEX_Valid     <= 1'b0;
      IDEX_rm        <= '0;
      IDEX_rn        <= '0;
      IDEX_rd        <= '0;
      IDEX_RegWrite  <= 1'b0;
      IDEX_MemRead   <= 1'b0;
      IDEX_Ctrl      <= '0;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_Imm       <= '0;
    end else begin
      IDEX_Valid     <= load;
      IDEX_rm        <= load ? IFID_rm : '0;
      IDEX_rn        <= load ? IFID_rn : '0;
      IDEX_rd        <= load ? IFID_rd : '0;
      IDEX_RegWrite  <= load & IFID_RegWrite;
      IDEX_MemRead   <= load & IFID_MemRead;
      IDEX_Ctrl      <= load ? IFID_Ctrl : '0;
      IDEX_ReadData1 <= load ? IFID_ReadData1 : '0;
      IDEX_ReadData2 <= load ? IFID_ReadData2 : '0;
      IDEX_Imm       <= load ? IFID_Imm : '0;
      if (Branching) begin
        state <= RUN;
        cnt   <= '0;
      end else if (state == RUN && hazard) begin
        state <= (STALL_CYCLES > 1) ? STALL : RUN;
        cnt   <= 3'(STALL_CYCLES - 1);
      end else if (state == STALL) begin
        cnt   <= cnt - 3'd1;
        state <= (cnt == 3'd1) ? RUN : STALL;
      end
    end
  end
`ifdef ID_EX_HAZARD_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      StallCount <= StallCount + {31'd0, Stall & ~&StallCount};
      FlushCount <= FlushCount + {31'd0, Branching & (IFID_Valid | (state == STALL)) & ~&FlushCount};
    end
  end
`endif
endmodule
